// File: rtl/spi_flash_ctrl_wrapper.sv
// SPI-flash command sequencer: runs one WREN, Page Program or Read frame per selector change
// through an internal SPI mode-0 master (SCLK = clk/2).
module spi_flash_ctrl_wrapper #(
   parameter logic [23:0] ADDR     = 24'h000010,
   parameter logic [31:0] WDATA    = 32'hF1BE37C6,
   parameter logic [7:0]  CMD_WREN = 8'h06,
   parameter logic [7:0]  CMD_PP   = 8'h02,
   parameter logic [7:0]  CMD_READ = 8'h03
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  selector,
   input  logic        MISO,
   output logic        SCLK,
   output logic        MOSI,
   output logic        CS_n,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StShift,
      StRecv,
      StStop,
      StGap
   } state_e;

   state_e      state_q;
   logic [1:0]  last_sel_q;
   logic [62:0] tx_q;
   logic [31:0] rx_q;
   logic [6:0]  bit_cnt_q;
   logic        is_read_q;
   logic        sclk_q;
   logic        mosi_q;
   logic        cs_n_q;
   logic [31:0] rdata_q;
   logic        rdata_valid_q;
   logic        busy_q;
   logic        done_q;

   logic        sel_known;
   logic        sel_idle;
   logic        start_frame;
   logic [63:0] load_bits;
   logic [6:0]  load_cnt;

   // Unknown selector values count as "no change" so a floating input never launches a frame.
   always_comb begin
      sel_known   = !$isunknown(selector);
      sel_idle    = sel_known && (selector == 2'b11);
      start_frame = sel_known && (selector != 2'b11) && (selector != last_sel_q);
      load_bits   = 64'h0;
      load_cnt    = 7'd0;
      case (selector)
         2'b00: begin
            load_bits = {CMD_WREN, 56'h0};
            load_cnt  = 7'd8;
         end
         2'b01: begin
            load_bits = {CMD_PP, ADDR, WDATA};
            load_cnt  = 7'd64;
         end
         2'b10: begin
            load_bits = {CMD_READ, ADDR, 32'h0};
            load_cnt  = 7'd32;
         end
         default: begin
            load_bits = 64'h0;
            load_cnt  = 7'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         last_sel_q    <= 2'b11;
         tx_q          <= '0;
         rx_q          <= '0;
         bit_cnt_q     <= '0;
         is_read_q     <= 1'b0;
         sclk_q        <= 1'b0;
         mosi_q        <= 1'b0;
         cs_n_q        <= 1'b1;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         rdata_valid_q <= 1'b0;
         done_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (sel_idle) begin
                  last_sel_q <= 2'b11;
               end else if (start_frame) begin
                  last_sel_q <= selector;
                  tx_q       <= load_bits[62:0];
                  mosi_q     <= load_bits[63];
                  bit_cnt_q  <= load_cnt;
                  is_read_q  <= (selector == 2'b10);
                  cs_n_q     <= 1'b0;
                  sclk_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               state_q <= StShift;
            end
            StShift, StRecv: begin
               if (!sclk_q) begin
                  sclk_q <= 1'b1;
               end else begin
                  // End of the SCLK-high cycle: sample MISO, then drop SCLK and present next bit.
                  sclk_q <= 1'b0;
                  if (state_q == StRecv) begin
                     rx_q <= {rx_q[30:0], MISO};
                  end
                  if (bit_cnt_q != 7'd1) begin
                     bit_cnt_q <= bit_cnt_q - 7'd1;
                     tx_q      <= {tx_q[61:0], 1'b0};
                     mosi_q    <= (state_q == StShift) ? tx_q[62] : 1'b0;
                  end else if ((state_q == StShift) && is_read_q) begin
                     bit_cnt_q <= 7'd32;
                     mosi_q    <= 1'b0;
                     state_q   <= StRecv;
                  end else begin
                     mosi_q  <= 1'b0;
                     cs_n_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= StStop;
                     if (state_q == StRecv) begin
                        rdata_q       <= {rx_q[30:0], MISO};
                        rdata_valid_q <= 1'b1;
                     end
                  end
               end
            end
            StStop: begin
               state_q <= StGap;
            end
            StGap: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign SCLK        = sclk_q;
   assign MOSI        = mosi_q;
   assign CS_n        = cs_n_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

   a_sclk_quiet_when_deselected: assert property (@(posedge clk) disable iff (!rst)
      CS_n |-> !SCLK);
   a_done_single_cycle: assert property (@(posedge clk) disable iff (!rst)
      done |=> !done);
   a_valid_with_done: assert property (@(posedge clk) disable iff (!rst)
      rdata_valid |-> done);

endmodule

// File: tb/tb_spi_flash_ctrl_wrapper.sv
// Directed bench for spi_flash_ctrl_wrapper: a bus monitor rebuilds each SPI frame and checks it
// against expected frames queued when the selector is driven.
module tb_spi_flash_ctrl_wrapper;

   localparam logic [23:0] A = 24'h000010;
   localparam logic [31:0] W = 32'hF1BE37C6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  selector = 2'b11;
   logic        MISO = 1'b0;
   logic        SCLK, MOSI, CS_n, rdata_valid, busy, done;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   spi_flash_ctrl_wrapper dut (
      .clk         (clk),
      .rst         (rst),
      .selector    (selector),
      .MISO        (MISO),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .CS_n        (CS_n),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      int          nbits;
      logic [63:0] bits;
      int          cs_low;
      bit          is_read;
      logic [31:0] rd;
      bit          aborted;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_busy = 1'b0;
   logic [63:0] cap = '0;
   logic [31:0] rx_word = '0;
   int          mon_cnt = 0;
   int          cs_low = 0;
   int          frames_seen = 0;
   int          busy_run = 0;
   int          last_busy_len = 0;
   int          done_total = 0;
   int          rv_total = 0;
   int          sclk_idle_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int nb, input logic [63:0] bits, input int csl, input bit rd,
                       input logic [31:0] rdv, input bit ab);
      exp_t e;
      e.nbits   = nb;
      e.bits    = bits;
      e.cs_low  = csl;
      e.is_read = rd;
      e.rd      = rdv;
      e.aborted = ab;
      exp_q.push_back(e);
   endtask

   task automatic frame_end();
      exp_t e;
      frames_seen++;
      check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("sclk_edges", 64'(mon_cnt), 64'(e.nbits));
         check("mosi_bits", cap, e.bits);
         check("cs_low_cycles", 64'(cs_low), 64'(e.cs_low));
         check("done_pulse", 64'(done), 64'(!e.aborted));
         check("rdata_valid", 64'(rdata_valid), 64'(e.is_read && !e.aborted));
         if (e.is_read && !e.aborted) check("rdata", 64'(rdata), 64'(e.rd));
      end
   endtask

   // Frame monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (done === 1'b1) done_total++;
      if (rdata_valid === 1'b1) rv_total++;
      if (CS_n === 1'b1 && SCLK === 1'b1) sclk_idle_err++;
      if (busy === 1'b1) begin
         busy_run++;
      end else if (prev_busy) begin
         last_busy_len = busy_run;
         busy_run      = 0;
      end
      prev_busy = (busy === 1'b1);
      if (CS_n === 1'b0) begin
         if (prev_cs) begin
            mon_cnt = 0;
            cap     = '0;
            cs_low  = 0;
         end
         cs_low++;
         if (SCLK === 1'b1 && !prev_sclk) begin
            cap = {cap[62:0], MOSI};
            mon_cnt++;
         end
      end else if (!prev_cs) begin
         frame_end();
      end
      prev_cs   = (CS_n !== 1'b0);
      prev_sclk = (SCLK === 1'b1);
   end

   // Flash model: read data changes after SCLK falls, once the command/address bits are out.
   always @(negedge SCLK) begin
      if (mon_cnt >= 32 && mon_cnt < 64) begin
         #1;
         MISO = rx_word[63 - mon_cnt];
      end
   end

   task automatic wait_idle(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_bound", 64'(n < max), 64'd1);
      @(negedge clk);
      #1;
   endtask

   initial begin : main
      int   r;
      int   n;
      logic ps;

      repeat (5) @(posedge clk);
      #1;
      check("rst_cs_n", 64'(CS_n), 64'd1);
      check("rst_sclk", 64'(SCLK), 64'd0);
      check("rst_mosi", 64'(MOSI), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_rvalid", 64'(rdata_valid), 64'd0);
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle_no_frame", 64'(frames_seen), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      push(8, 64'h06, 17, 1'b0, 32'h0, 1'b0);
      selector = 2'b00;
      wait_idle(100);
      repeat (50) @(posedge clk);
      #1;
      check("wren_no_repeat", 64'(frames_seen), 64'd1);

      push(64, {8'h02, A, W}, 129, 1'b0, 32'h0, 1'b0);
      selector = 2'b01;
      wait_idle(400);
      check("pp_busy_len", 64'(last_busy_len), 64'd131);
      push(8, 64'h06, 17, 1'b0, 32'h0, 1'b0);
      selector = 2'b00;
      wait_idle(100);

      rx_word = W;
      push(64, {8'h03, A, 32'h0}, 129, 1'b1, W, 1'b0);
      selector = 2'b10;
      wait_idle(400);
      check("rdata_hold", 64'(rdata), 64'(W));

      push(64, {8'h02, A, W}, 129, 1'b0, 32'h0, 1'b0);
      selector = 2'b01;
      repeat (30) @(posedge clk);
      #1;
      check("pp_mid_busy", 64'(busy), 64'd1);
      push(8, 64'h06, 17, 1'b0, 32'h0, 1'b0);
      selector = 2'b00;
      wait_idle(600);

      // Abort a Page Program right after its 20th SCLK rising edge.
      push(20, {8'h02, A, W} >> 44, 41, 1'b0, 32'h0, 1'b1);
      selector = 2'b01;
      r  = 0;
      n  = 0;
      ps = 1'b0;
      while (r < 20 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
         if (SCLK === 1'b1 && !ps) r++;
         ps = (SCLK === 1'b1);
      end
      check("bit20_reached", 64'(r), 64'd20);
      rst      = 1'b0;
      selector = 2'b11;
      @(posedge clk);
      #1;
      check("abort_cs_n", 64'(CS_n), 64'd1);
      check("abort_sclk", 64'(SCLK), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_rvalid", 64'(rdata_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rdata", 64'(rdata), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_idle(50);

      rx_word = 32'h5A3C96E1;
      push(64, {8'h03, A, 32'h0}, 129, 1'b1, 32'h5A3C96E1, 1'b0);
      selector = 2'b10;
      wait_idle(400);
      selector = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      rx_word = 32'h0F0FA5C3;
      push(64, {8'h03, A, 32'h0}, 129, 1'b1, 32'h0F0FA5C3, 1'b0);
      selector = 2'b10;
      wait_idle(400);
      repeat (50) @(posedge clk);
      #1;
      check("read_no_repeat", 64'(frames_seen), 64'd9);

      check("done_total", 64'(done_total), 64'd8);
      check("rvalid_total", 64'(rv_total), 64'd3);
      check("sclk_while_idle", 64'(sclk_idle_err), 64'd0);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_flash_ctrl_wrapper.md
Name: spi_flash_ctrl_wrapper

Overview:
Top-level SPI-flash command sequencer. A 2-bit selector picks one of three fixed flash transactions: Write Enable, Page Program, or Read. The block runs that transaction once through an internal SPI mode-0 master. It sits between system control logic and an external serial NOR flash. The address and write data come from parameters; read data is captured into a 32-bit register.

Parameters:
ADDR, 24'h000010, flash address used by Page Program and Read
WDATA, 32'hF1BE37C6, data word sent by Page Program
CMD_WREN, 8'h06, Write Enable opcode
CMD_PP, 8'h02, Page Program opcode
CMD_READ, 8'h03, Read Data opcode

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
selector  input  2  00=WREN, 01=Page Program, 10=Read, 11=idle/no-op
MISO  input  1  serial data from flash
SCLK  output  1  SPI clock, clk/2, idle low
MOSI  output  1  serial data to flash, MSB first
CS_n  output  1  flash chip select, active low
rdata  output  32  last word read
rdata_valid  output  1  one-cycle pulse when rdata updates
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at end of any frame

Behaviour:
- Reset (rst=0 at a clk edge):
  - SCLK=0, MOSI=0, CS_n=1, busy=0, done=0, rdata=0, rdata_valid=0.
  - State=IDLE; last_sel register=2'b11.
  - Reset mid-frame aborts immediately, with the same values.
- Trigger rule:
  - In IDLE, when selector != last_sel and selector != 11, latch selector into last_sel and start the frame.
  - A selector held constant never repeats a frame.
  - A selector change during a frame is ignored until IDLE; it is then evaluated against last_sel.
  - selector=11 sets last_sel=11 without a frame, so the next non-11 value retriggers.
  - X/Z on selector is treated as no change.
- Frame contents, MSB first:
  - WREN: 8 bits (CMD_WREN).
  - PP: 64 bits (CMD_PP, ADDR, WDATA).
  - READ: 32 bits out (CMD_READ, ADDR), then 32 bits in; MOSI is held 0 during the read phase.
- States: IDLE -> START -> SHIFT -> (READ only) RECV -> STOP -> GAP -> IDLE.
- START (1 cycle): CS_n=0, MOSI=first bit, SCLK=0, busy=1.
- SHIFT/RECV timing:
  - Each bit takes 2 clk cycles: SCLK low cycle, then SCLK high cycle (SPI mode 0).
  - MOSI changes only while SCLK is low.
  - MISO is sampled on the clk edge ending the SCLK-high cycle and shifted into rdata_shift LSB-first-in, so the first bit received becomes rdata[31].
- Bit counter: 7 bits, counts down; SHIFT ends after the last bit's high phase.
- STOP (1 cycle): SCLK=0, CS_n=1, done=1.
  - For READ: rdata=rdata_shift and rdata_valid=1 in the same cycle.
- GAP (1 cycle): CS_n stays high (minimum 2 clk cycles CS_n high between frames); busy falls on leaving GAP.
- Frame latency, START through STOP:
  - WREN: 1+16+1 = 18 cycles.
  - PP: 1+128+1 = 130 cycles.
  - READ: 1+64+64+1 = 130 cycles.
- SCLK never toggles while CS_n=1.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> CS_n=1, SCLK=0, busy=0, rdata=0; release with selector=11 -> no activity.
- WREN: selector 11->00 -> CS_n low for 16 cycles of SCLK activity; 8 SCLK rising edges; MOSI bits 0000_0110; done pulses once; holding 00 for 500 ns produces no second frame.
- Page Program: selector 00->01 -> 64 SCLK rising edges; MOSI = 0x02, 0x000010, 0xF1BE37C6; busy high for 131 cycles; then selector 01->00 -> new WREN frame.
- Read: selector 00->10, drive MISO with 0xF1BE37C6 MSB first, changing on SCLK falling edges after the 32nd command/address bit -> rdata=0xF1BE37C6 with a one-cycle rdata_valid; MOSI=0 during the read phase.
- Mid-frame events: change selector during a PP frame -> the frame completes unaltered, then the new selector is executed; assert rst at bit 20 -> CS_n=1 and SCLK=0 on the next edge; no done or rdata_valid pulse.
- Retrigger via idle: selector 10->11->10 -> a second read frame occurs; 10 held constant -> exactly one frame.
